// File: rtl/vfpu_result_packer_pkg.sv
`default_nettype none
// vfpu_package: shared state, control and flag types for vfpu_result_packer. Rev 1.0
package vfpu_package;

  localparam int unsigned PACKER_LEN_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } packer_state_t;

  typedef struct packed {
    logic                    start;
    logic [PACKER_LEN_W-1:0] len;
  } ctrl_packer_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_packer_t;

endpackage
`default_nettype wire

// File: rtl/hwpe_stream_intf_stream.sv
`default_nettype none
// hwpe_stream_intf_stream: valid/ready stream with byte strobes. Rev 1.0
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);
endinterface
`default_nettype wire

// File: rtl/vfpu_pack_outreg.sv
`default_nettype none
// vfpu_pack_outreg: single-entry output register holding data/strb until handshake. Rev 1.0
module vfpu_pack_outreg #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clear,
  input  logic                    i_load,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [DATA_WIDTH/8-1:0] o_strb,
  output logic                    o_free
);

  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH/8-1:0] r_strb;

  // Callers only load when o_free is high, so a pending word is never overwritten.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_strb  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_strb  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_strb  <= i_strb;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_strb  = r_strb;
  assign o_free  = !r_valid || i_ready;

endmodule
`default_nettype wire

// File: rtl/vfpu_result_packer.sv
`default_nettype none
// vfpu_result_packer: packs IN_WIDTH FPU results into DATA_WIDTH words, lane 0 first. Rev 1.0
// Optional back-pressure counter stall_cnt_o enabled by VFPU_PACKER_STALL_CNT_EN.
module vfpu_result_packer
  import vfpu_package::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   start_i,
  input  logic [LEN_WIDTH-1:0]   len_i,
  hwpe_stream_intf_stream.sink   in_stream,
  hwpe_stream_intf_stream.source out_stream,
  output logic                   busy_o,
  output logic                   done_o
`ifdef VFPU_PACKER_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  localparam int unsigned c_lanes    = DATA_WIDTH / IN_WIDTH;
  localparam int unsigned c_in_strb  = IN_WIDTH / 8;
  localparam int unsigned c_out_strb = DATA_WIDTH / 8;
  localparam int unsigned c_lane_w   = (c_lanes > 1) ? $clog2(c_lanes) : 1;

  packer_state_t           r_state;
  flags_packer_t           r_flags;
  logic [c_lane_w-1:0]     r_lane;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [DATA_WIDTH-1:0]   r_pack_data;
  logic [c_out_strb-1:0]   r_pack_strb;
  logic                    r_full;

  ctrl_packer_t            w_ctrl;
  logic                    w_in_ready;
  logic                    w_acc;
  logic                    w_xfer_held;
  logic                    w_fill_full;
  logic                    w_hold_new;
  logic                    w_load;
  logic [c_lane_w-1:0]     w_base_lane;
  logic [LEN_WIDTH-1:0]    w_rem_next;
  logic [DATA_WIDTH-1:0]   w_new_data;
  logic [c_out_strb-1:0]   w_new_strb;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [c_out_strb-1:0]   w_load_strb;
  logic                    w_out_valid;
  logic [DATA_WIDTH-1:0]   w_out_data;
  logic [c_out_strb-1:0]   w_out_strb;
  logic                    w_out_free;

  always_comb begin
    w_ctrl.start = start_i && (r_state == IDLE);
    w_ctrl.len   = PACKER_LEN_W'(len_i);

    // A held full pack blocks input only while the output register cannot take it.
    w_in_ready  = (r_state == PACK) && (r_rem != '0) && !(r_full && !w_out_free);
    w_acc       = w_in_ready && in_stream.valid;
    w_xfer_held = (r_state == PACK) && r_full && w_out_free;

    // When the held pack leaves this cycle, a new element starts a fresh pack at lane 0.
    w_base_lane = r_full ? '0 : r_lane;
    w_new_data  = r_full ? '0 : r_pack_data;
    w_new_strb  = r_full ? '0 : r_pack_strb;
    for (int i = 0; i < c_lanes; i++) begin
      if (w_acc && (c_lane_w'(i) == w_base_lane)) begin
        w_new_data[i*IN_WIDTH +: IN_WIDTH]   = in_stream.data;
        w_new_strb[i*c_in_strb +: c_in_strb] = in_stream.strb;
      end
    end

    w_fill_full = w_acc && ((w_base_lane == c_lane_w'(c_lanes - 1)) || (r_rem == LEN_WIDTH'(1)));
    w_hold_new  = w_fill_full && (r_full || !w_out_free);
    w_load      = w_xfer_held || (w_fill_full && !r_full && w_out_free);
    w_load_data = w_xfer_held ? r_pack_data : w_new_data;
    w_load_strb = w_xfer_held ? r_pack_strb : w_new_strb;
    w_rem_next  = w_acc ? (r_rem - LEN_WIDTH'(1)) : r_rem;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_flags     <= '0;
      r_lane      <= '0;
      r_rem       <= '0;
      r_pack_data <= '0;
      r_pack_strb <= '0;
      r_full      <= 1'b0;
    end else if (clear_i) begin
      r_state     <= IDLE;
      r_flags     <= '0;
      r_lane      <= '0;
      r_rem       <= '0;
      r_pack_data <= '0;
      r_pack_strb <= '0;
      r_full      <= 1'b0;
    end else begin
      r_flags.done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ctrl.start) begin
            if (w_ctrl.len != '0) begin
              r_rem         <= LEN_WIDTH'(w_ctrl.len);
              r_lane        <= '0;
              r_state       <= PACK;
              r_flags.busy  <= 1'b1;
            end else begin
              r_state      <= DONE;
              r_flags.done <= 1'b1;
            end
          end
        end
        PACK: begin
          r_rem <= w_rem_next;
          if (w_hold_new) begin
            r_pack_data <= w_new_data;
            r_pack_strb <= w_new_strb;
            r_lane      <= '0;
            r_full      <= 1'b1;
          end else if (!r_full || w_out_free) begin
            r_full <= 1'b0;
            if (w_fill_full) begin
              r_pack_data <= '0;
              r_pack_strb <= '0;
              r_lane      <= '0;
            end else begin
              r_pack_data <= w_new_data;
              r_pack_strb <= w_new_strb;
              r_lane      <= w_base_lane + c_lane_w'(w_acc);
            end
          end
          if (w_load && !w_hold_new && (w_rem_next == '0)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_out_free) begin
            r_state      <= DONE;
            r_flags.busy <= 1'b0;
            r_flags.done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  vfpu_pack_outreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outreg (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clear (clear_i),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_strb  (w_load_strb),
    .i_ready (out_stream.ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_data),
    .o_strb  (w_out_strb),
    .o_free  (w_out_free)
  );

  assign in_stream.ready  = w_in_ready;
  assign out_stream.valid = w_out_valid;
  assign out_stream.data  = w_out_data;
  assign out_stream.strb  = w_out_strb;
  assign busy_o           = r_flags.busy;
  assign done_o           = r_flags.done;

`ifdef VFPU_PACKER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= '0;
    end else if (clear_i || w_ctrl.start) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !out_stream.ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire
